// File: rtl/le_cond_capture_array.sv
// rtl/le_cond_capture_array.sv - multi-channel condition-token capture with combined AND/OR result
//
// Each channel captures {cond, valid} tokens into a private DEPTH-entry FIFO.
// The heads of all enabled channels combine into one token, which I_Ack consumes.
//
// Optional build macro: LE_COND_OVF_EN
//   Defined:   builds a sticky per-channel drop flag on O_Ovf.
//   Undefined: O_Ovf is tied to 0.
//
// Ports:
//   clock      in   clock
//   reset      in   synchronous, active-high reset
//   I_Clr      in   clear all channels
//   I_ClrCh    in   per-channel clear [NUM_CH]
//   I_InC      in   tokens [2*NUM_CH]: bit 2k = valid, bit 2k+1 = cond
//   I_En       in   channel participates in the combined result [NUM_CH]
//   I_Ack      in   consume the current combined token
//   O_Valid    out  combined token available
//   O_Cond     out  combined condition (0 when O_Valid=0)
//   O_ChValid  out  channel FIFO non-empty [NUM_CH]
//   O_ChCond   out  channel head cond bit, 0 when empty [NUM_CH]
//   O_Full     out  channel FIFO holds DEPTH entries [NUM_CH]
//   O_Ovf      out  sticky drop flag [NUM_CH]
module le_cond_capture_array #(
  parameter int NUM_CH  = 4,
  parameter int DEPTH   = 2,
  parameter int COMBINE = 0
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                I_Clr,
  input  logic [NUM_CH-1:0]   I_ClrCh,
  input  logic [2*NUM_CH-1:0] I_InC,
  input  logic [NUM_CH-1:0]   I_En,
  input  logic                I_Ack,
  output logic                O_Valid,
  output logic                O_Cond,
  output logic [NUM_CH-1:0]   O_ChValid,
  output logic [NUM_CH-1:0]   O_ChCond,
  output logic [NUM_CH-1:0]   O_Full,
  output logic [NUM_CH-1:0]   O_Ovf
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [NUM_CH-1:0] ch_valid;
  logic [NUM_CH-1:0] ch_full;
  logic [NUM_CH-1:0] head;
  logic [NUM_CH-1:0] pop;
  logic              all_ready;
  logic              and_cond;
  logic              or_cond;

  // Disabled channels count as ready so they never block the combined token.
  assign all_ready = &(ch_valid | ~I_En);
  assign O_Valid   = (|I_En) & all_ready;

  // Disabled channels are neutral elements of each reduction.
  assign and_cond = &(head | ~I_En);
  assign or_cond  = |(head & I_En);
  assign O_Cond   = O_Valid & ((COMBINE != 0) ? or_cond : and_cond);

  assign O_ChValid = ch_valid;
  assign O_ChCond  = head;
  assign O_Full    = ch_full;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    logic [DEPTH-1:0] mem;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             clear;
    logic             tok_valid;
    logic             tok_cond;
    logic             push;

    assign clear     = I_Clr | I_ClrCh[k];
    assign tok_valid = I_InC[2*k];
    assign tok_cond  = I_InC[2*k+1];

    assign ch_valid[k] = (count != '0);
    assign ch_full[k]  = (count == CW'(DEPTH));
    assign head[k]     = mem[rd_ptr] & ch_valid[k];
    assign pop[k]      = I_Ack & O_Valid & I_En[k];
    // A full channel still accepts a token when its head leaves in the same cycle.
    assign push        = tok_valid & (~ch_full[k] | pop[k]);

    // Storage carries no reset: entries beyond count are never observed.
    always_ff @(posedge clock) begin
      if (!reset && !clear && push) begin
        mem[wr_ptr] <= tok_cond;
      end
    end

    always_ff @(posedge clock) begin
      if (reset || clear) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) begin
          wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
        end
        if (pop[k]) begin
          rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
        end
        if (push && !pop[k]) begin
          count <= count + CW'(1);
        end else if (!push && pop[k]) begin
          count <= count - CW'(1);
        end
      end
    end

`ifdef LE_COND_OVF_EN
    logic ovf_q;

    always_ff @(posedge clock) begin
      if (reset || clear) begin
        ovf_q <= 1'b0;
      end else if (tok_valid && ch_full[k] && !pop[k]) begin
        ovf_q <= 1'b1;
      end
    end

    assign O_Ovf[k] = ovf_q;
`else
    assign O_Ovf[k] = 1'b0;
`endif
  end

endmodule

// File: tb/tb_le_cond_capture_array.sv
// tb/tb_le_cond_capture_array.sv - directed table-driven bench for le_cond_capture_array
module tb_le_cond_capture_array;

`ifdef LE_COND_OVF_EN
  localparam logic [3:0] OVF_MASK = 4'hF;
`else
  localparam logic [3:0] OVF_MASK = 4'h0;
`endif

  logic       clock = 1'b0;
  logic       reset;
  logic       I_Clr;
  logic [3:0] I_ClrCh;
  logic [7:0] I_InC;
  logic [3:0] I_En;
  logic       I_Ack;

  logic       a_valid, a_cond;
  logic [3:0] a_chv, a_chc, a_full, a_ovf;
  logic       o_valid, o_cond;
  logic [3:0] o_chv, o_chc, o_full, o_ovf;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  le_cond_capture_array #(.NUM_CH(4), .DEPTH(2), .COMBINE(0)) dut_and (
    .clock(clock), .reset(reset), .I_Clr(I_Clr), .I_ClrCh(I_ClrCh), .I_InC(I_InC),
    .I_En(I_En), .I_Ack(I_Ack), .O_Valid(a_valid), .O_Cond(a_cond),
    .O_ChValid(a_chv), .O_ChCond(a_chc), .O_Full(a_full), .O_Ovf(a_ovf)
  );

  le_cond_capture_array #(.NUM_CH(4), .DEPTH(2), .COMBINE(1)) dut_or (
    .clock(clock), .reset(reset), .I_Clr(I_Clr), .I_ClrCh(I_ClrCh), .I_InC(I_InC),
    .I_En(I_En), .I_Ack(I_Ack), .O_Valid(o_valid), .O_Cond(o_cond),
    .O_ChValid(o_chv), .O_ChCond(o_chc), .O_Full(o_full), .O_Ovf(o_ovf)
  );

  typedef struct {
    logic       clr;
    logic [3:0] clrch;
    logic [7:0] inc;
    logic [3:0] en;
    logic       ack;
    logic       v;
    logic       c;
    logic [3:0] chv;
    logic [3:0] chc;
    logic [3:0] full;
    logic [3:0] ovf;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic clr, input logic [3:0] clrch, input logic [7:0] inc,
                     input logic [3:0] en, input logic ack, input logic v, input logic c,
                     input logic [3:0] chv, input logic [3:0] chc, input logic [3:0] full,
                     input logic [3:0] ovf);
    vec_t r;
    r.clr = clr; r.clrch = clrch; r.inc = inc; r.en = en; r.ack = ack;
    r.v = v; r.c = c; r.chv = chv; r.chc = chc; r.full = full; r.ovf = ovf;
    tbl.push_back(r);
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic clr, input logic [3:0] clrch, input logic [7:0] inc,
                       input logic [3:0] en, input logic ack);
    @(negedge clock);
    I_Clr = clr; I_ClrCh = clrch; I_InC = inc; I_En = en; I_Ack = ack;
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1; I_Clr = 1'b0; I_ClrCh = 4'h0; I_InC = 8'h00; I_En = 4'b0011; I_Ack = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("reset_valid", {7'd0, a_valid}, 8'd0);
    check("reset_cond",  {7'd0, a_cond},  8'd0);
    check("reset_chv",   {4'd0, a_chv},   8'd0);
    check("reset_chc",   {4'd0, a_chc},   8'd0);
    check("reset_full",  {4'd0, a_full},  8'd0);
    check("reset_ovf",   {4'd0, a_ovf},   8'd0);
    @(negedge clock);
    reset = 1'b0;

    //   clr clrch  inc           en      ack  v  c  chv     chc     full    ovf
    // single capture on ch0/ch1, then ack
    add(0, 4'h0, 8'b00_00_11_11, 4'b0011, 0,  1, 1, 4'b0011, 4'b0011, 4'b0000, 4'b0000);
    add(0, 4'h0, 8'b00_00_00_00, 4'b0011, 1,  0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    // fill ch0 with 1,0 then drop a third token
    add(0, 4'h0, 8'b00_00_00_11, 4'b0001, 0,  1, 1, 4'b0001, 4'b0001, 4'b0000, 4'b0000);
    add(0, 4'h0, 8'b00_00_00_01, 4'b0001, 0,  1, 1, 4'b0001, 4'b0001, 4'b0001, 4'b0000);
    add(0, 4'h0, 8'b00_00_00_11, 4'b0001, 0,  1, 1, 4'b0001, 4'b0001, 4'b0001, 4'b0001);
    add(0, 4'h0, 8'b00_00_00_00, 4'b0001, 1,  1, 0, 4'b0001, 4'b0000, 4'b0000, 4'b0001);
    add(0, 4'h0, 8'b00_00_00_00, 4'b0001, 1,  0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0001);
    add(0, 4'h1, 8'b00_00_00_00, 4'b0001, 0,  0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    // full channel with simultaneous push and pop
    add(0, 4'h0, 8'b00_00_00_11, 4'b0001, 0,  1, 1, 4'b0001, 4'b0001, 4'b0000, 4'b0000);
    add(0, 4'h0, 8'b00_00_00_01, 4'b0001, 0,  1, 1, 4'b0001, 4'b0001, 4'b0001, 4'b0000);
    add(0, 4'h0, 8'b00_00_00_11, 4'b0001, 1,  1, 0, 4'b0001, 4'b0000, 4'b0001, 4'b0000);
    add(0, 4'h0, 8'b00_00_00_00, 4'b0001, 1,  1, 1, 4'b0001, 4'b0001, 4'b0000, 4'b0000);
    add(0, 4'h0, 8'b00_00_00_00, 4'b0001, 1,  0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    // clear priority
    add(0, 4'h0, 8'b00_01_11_11, 4'b0111, 0,  1, 0, 4'b0111, 4'b0011, 4'b0000, 4'b0000);
    add(0, 4'h2, 8'b00_00_11_00, 4'b0010, 1,  0, 0, 4'b0101, 4'b0001, 4'b0000, 4'b0000);
    add(0, 4'h0, 8'b00_01_00_00, 4'b0010, 0,  0, 0, 4'b0101, 4'b0001, 4'b0100, 4'b0000);
    add(0, 4'h0, 8'b00_11_00_00, 4'b0010, 0,  0, 0, 4'b0101, 4'b0001, 4'b0100, 4'b0100);
    add(1, 4'h0, 8'b11_11_11_11, 4'b1111, 0,  0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    // mask edge cases
    add(0, 4'h0, 8'b11_11_11_11, 4'b0000, 0,  0, 0, 4'b1111, 4'b1111, 4'b0000, 4'b0000);
    add(0, 4'h0, 8'b00_00_00_00, 4'b0000, 1,  0, 0, 4'b1111, 4'b1111, 4'b0000, 4'b0000);
    add(0, 4'h0, 8'b00_00_00_00, 4'b1111, 0,  1, 1, 4'b1111, 4'b1111, 4'b0000, 4'b0000);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].clr, tbl[i].clrch, tbl[i].inc, tbl[i].en, tbl[i].ack);
      check($sformatf("row%0d_valid", i), {7'd0, a_valid}, {7'd0, tbl[i].v});
      check($sformatf("row%0d_cond", i),  {7'd0, a_cond},  {7'd0, tbl[i].c});
      check($sformatf("row%0d_chv", i),   {4'd0, a_chv},   {4'd0, tbl[i].chv});
      check($sformatf("row%0d_chc", i),   {4'd0, a_chc},   {4'd0, tbl[i].chc});
      check($sformatf("row%0d_full", i),  {4'd0, a_full},  {4'd0, tbl[i].full});
      check($sformatf("row%0d_ovf", i),   {4'd0, a_ovf},   {4'd0, tbl[i].ovf & OVF_MASK});
    end

    // OR combine: heads 0,0,1,0 across all four channels
    drive(1, 4'h0, 8'h00, 4'b1111, 0);
    check("or_clr_chv", {4'd0, o_chv}, 8'd0);
    drive(0, 4'h0, 8'b01_11_01_01, 4'b1111, 0);
    check("or_mix_valid", {7'd0, o_valid}, 8'd1);
    check("or_mix_cond",  {7'd0, o_cond},  8'd1);
    check("and_mix_cond", {7'd0, a_cond},  8'd0);
    drive(0, 4'h0, 8'h00, 4'b1111, 1);
    check("or_ack_valid", {7'd0, o_valid}, 8'd0);
    check("or_ack_chv",   {4'd0, o_chv},   8'd0);
    drive(0, 4'h0, 8'b01_01_01_01, 4'b1111, 0);
    check("or_zero_valid", {7'd0, o_valid}, 8'd1);
    check("or_zero_cond",  {7'd0, o_cond},  8'd0);
    // ch2 cleared while a ch2 token arrives: token discarded, ch2 empty
    drive(0, 4'b0100, 8'b00_11_00_00, 4'b1111, 0);
    check("or_ch2_valid", {7'd0, o_valid}, 8'd0);
    check("or_ch2_cond",  {7'd0, o_cond},  8'd0);
    check("or_ch2_chv",   {4'd0, o_chv},   8'b0000_1011);

    // reset mid-operation with tokens presented
    @(negedge clock);
    reset = 1'b1; I_InC = 8'hFF; I_Ack = 1'b0; I_En = 4'b1111;
    @(posedge clock);
    #1;
    check("rst_mid_valid", {7'd0, a_valid}, 8'd0);
    check("rst_mid_chv",   {4'd0, a_chv},   8'd0);
    check("rst_mid_full",  {4'd0, a_full},  8'd0);
    check("rst_mid_ovf",   {4'd0, a_ovf},   8'd0);
    @(negedge clock);
    reset = 1'b0; I_InC = 8'h00;
    @(posedge clock);
    #1;
    check("post_rst_chv", {4'd0, a_chv}, 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
